wb_sched: RTL and testbench

Memory-side scheduler that shares the single DDR command port between the read-request queue and the write path (write-address queue plus 128-bit write buffer). It arbitrates reads against writes with read priority, a write-starvation bound and write batching. For each granted write it pops exactly BURST_WORDS data words from the write buffer, paced by the DDR datapath. It sits between the request FIFOs and the DDR command sequencer, in the Rclk domain.

---
 rtl/wb_sched.sv | 156 +++++++++++++++
 tb/tb_wb_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// DDR command-port scheduler: arbitrates the read-request queue against the write path
// with read priority, a write-starvation bound and write batching; paces write-buffer pops.
module wb_sched #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned BURST_WORDS = 2,
  parameter int unsigned WR_STARVE   = 64,
  parameter int unsigned WR_BATCH    = 8
) (
  input  logic              Rclk,
  input  logic              Reset,
  input  logic              RAvalid,
  input  logic [ADDR_W-1:0] RAaddr,
  output logic              RAre,
  input  logic              WAvalid,
  input  logic [ADDR_W-1:0] WAaddr,
  output logic              WAre,
  input  logic              WBempty,
  output logic              WBre,
  output logic              DcmdValid,
  output logic              DcmdWrite,
  output logic [ADDR_W-1:0] DcmdAddr,
  input  logic              DcmdReady,
  input  logic              DwrNext,
  output logic              Underrun,
  output logic              Busy
);

  localparam int unsigned STARVE_W = 8;
  localparam int unsigned BATCH_W  = 4;
  localparam int unsigned WORD_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_CMD  = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [BATCH_W-1:0]  batch_q, batch_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic                wr_elig;
  logic                rd_pop, wr_pop, wb_pop;

  // State and registered outputs
  always_ff @(posedge Rclk) begin
    if (Reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      batch_q     <= '0;
      word_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      batch_q     <= batch_d;
      word_q      <= word_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  // Arbitration, command issue and burst pacing
  always_comb begin
    state_d     = state_q;
    batch_d     = batch_q;
    word_d      = word_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    rd_pop      = 1'b0;
    wr_pop      = 1'b0;
    wb_pop      = 1'b0;
    wr_elig     = WAvalid && !WBempty;

    unique case (state_q)
      IDLE: begin
        if (wr_elig && (starve_q == STARVE_W'(WR_STARVE) || !RAvalid)) begin
          state_d     = WR_CMD;
          batch_d     = '0;
          cmd_write_d = 1'b1;
          cmd_addr_d  = WAaddr;
        end else if (RAvalid) begin
          state_d     = RD_CMD;
          cmd_write_d = 1'b0;
          cmd_addr_d  = RAaddr;
        end
      end
      RD_CMD: begin
        if (DcmdReady) begin
          rd_pop  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_CMD: begin
        if (DcmdReady) begin
          wr_pop  = 1'b1;
          batch_d = batch_q + BATCH_W'(1);
          word_d  = WORD_W'(BURST_WORDS);
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (DwrNext) begin
          wb_pop = 1'b1;
          word_d = word_q - WORD_W'(1);
          if (word_q == WORD_W'(1)) begin
            // Chain the next write without an IDLE bubble while the batch allows it
            if (wr_elig && (batch_q < BATCH_W'(WR_BATCH) || !RAvalid)) begin
              state_d     = WR_CMD;
              cmd_write_d = 1'b1;
              cmd_addr_d  = WAaddr;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    starve_d = starve_q;
    if (!WAvalid || wr_pop) begin
      starve_d = '0;
    end else if (wr_elig && state_q != WR_CMD && state_q != WR_DATA &&
                 starve_q != STARVE_W'(WR_STARVE)) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    cmd_valid_d = (state_d == RD_CMD) || (state_d == WR_CMD);
    busy_d      = (state_d != IDLE);
    underrun_d  = underrun_q || ((state_q == WR_DATA) && DwrNext && WBempty);
  end

  assign RAre      = rd_pop;
  assign WAre      = wr_pop;
  assign WBre      = wb_pop;
  assign DcmdValid = cmd_valid_q;
  assign DcmdWrite = cmd_write_q;
  assign DcmdAddr  = cmd_addr_q;
  assign Busy      = busy_q;
  assign Underrun  = underrun_q;

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: a per-cycle vector table for reads and a single write burst,
// followed by hand-written starvation, batching, stall, underrun and reset sequences.
module tb_wb_sched;

  localparam int unsigned AW = 27;

  logic          Rclk, Reset;
  logic          RAvalid, RAre, WAvalid, WAre, WBempty, WBre;
  logic [AW-1:0] RAaddr, WAaddr, DcmdAddr;
  logic          DcmdValid, DcmdWrite, DcmdReady, DwrNext, Underrun, Busy;

  int n_vec  = 0;
  int n_miss = 0;

  wb_sched #(.ADDR_W(AW), .BURST_WORDS(2), .WR_STARVE(64), .WR_BATCH(8)) dut (
    .Rclk(Rclk), .Reset(Reset),
    .RAvalid(RAvalid), .RAaddr(RAaddr), .RAre(RAre),
    .WAvalid(WAvalid), .WAaddr(WAaddr), .WAre(WAre),
    .WBempty(WBempty), .WBre(WBre),
    .DcmdValid(DcmdValid), .DcmdWrite(DcmdWrite), .DcmdAddr(DcmdAddr),
    .DcmdReady(DcmdReady), .DwrNext(DwrNext),
    .Underrun(Underrun), .Busy(Busy)
  );

  initial Rclk = 1'b0;
  always #5 Rclk = ~Rclk;

  typedef struct {
    logic          rav;
    logic [AW-1:0] raa;
    logic          wav;
    logic [AW-1:0] waa;
    logic          wbe, rdy, dwn;
    logic          e_val, e_wr;
    logic [AW-1:0] e_addr;
    logic          e_rare, e_ware, e_wbre, e_busy, e_unr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rav, input logic [AW-1:0] raa,
                              input logic wav, input logic [AW-1:0] waa,
                              input logic wbe, input logic rdy, input logic dwn,
                              input logic e_val, input logic e_wr, input logic [AW-1:0] e_addr,
                              input logic e_rare, input logic e_ware, input logic e_wbre,
                              input logic e_busy, input logic e_unr);
    vec_t v;
    v.rav = rav; v.raa = raa; v.wav = wav; v.waa = waa;
    v.wbe = wbe; v.rdy = rdy; v.dwn = dwn;
    v.e_val = e_val; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_rare = e_rare; v.e_ware = e_ware; v.e_wbre = e_wbre;
    v.e_busy = e_busy; v.e_unr = e_unr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RAvalid = 1'b0; RAaddr = '0; WAvalid = 1'b0; WAaddr = '0;
    WBempty = 1'b1; DcmdReady = 1'b0; DwrNext = 1'b0;
  endtask

  // Leaves the caller just after a posedge with Reset released for the next edge
  task automatic do_reset();
    @(posedge Rclk); #1;
    Reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge Rclk);
    #1 Reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " DcmdValid"}, 64'(DcmdValid), 64'd0);
    chk({tag, " DcmdWrite"}, 64'(DcmdWrite), 64'd0);
    chk({tag, " DcmdAddr"},  64'(DcmdAddr),  64'd0);
    chk({tag, " RAre"},      64'(RAre),      64'd0);
    chk({tag, " WAre"},      64'(WAre),      64'd0);
    chk({tag, " WBre"},      64'(WBre),      64'd0);
    chk({tag, " Underrun"},  64'(Underrun),  64'd0);
    chk({tag, " Busy"},      64'(Busy),      64'd0);
  endtask

  logic          acc_wr[16];
  logic [AW-1:0] acc_addr[16];

  initial begin
    int  nrd, nwb, nacc, extra_wr, k;
    bit  found, got_rd, pop;

    Reset = 1'b1;
    clear_inputs();

    // rav raa wav waa wbe rdy dwn | val wr addr rare ware wbre busy unr
    tbl.push_back(mk(1, 27'h10, 0, 27'h0,   1, 1, 0,  0, 0, 27'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 27'h10, 0, 27'h0,   1, 1, 0,  1, 0, 27'h10,  1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 27'h11, 0, 27'h0,   1, 1, 0,  0, 0, 27'h10,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 27'h11, 0, 27'h0,   1, 1, 0,  1, 0, 27'h11,  1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 27'h12, 0, 27'h0,   1, 1, 0,  0, 0, 27'h11,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 27'h12, 0, 27'h0,   1, 1, 0,  1, 0, 27'h12,  1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 27'h13, 0, 27'h0,   1, 1, 0,  0, 0, 27'h12,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 27'h13, 0, 27'h0,   1, 1, 0,  1, 0, 27'h13,  1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   1, 1, 0,  0, 0, 27'h13,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 27'h0,  1, 27'h100, 0, 1, 0,  0, 0, 27'h13,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 27'h0,  1, 27'h100, 0, 1, 0,  1, 1, 27'h100, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   0, 1, 0,  0, 1, 27'h100, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   0, 1, 1,  0, 1, 27'h100, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   0, 1, 0,  0, 1, 27'h100, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   0, 1, 1,  0, 1, 27'h100, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   1, 1, 0,  0, 1, 27'h100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   1, 1, 1,  0, 1, 27'h100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 27'h0,  0, 27'h0,   1, 1, 0,  0, 1, 27'h100, 0, 0, 0, 0, 0));

    do_reset();
    @(negedge Rclk);
    chk_reset_vals("reset");

    // Per-cycle table: drive after the edge, compare on the falling edge
    foreach (tbl[i]) begin
      @(posedge Rclk); #1;
      RAvalid = tbl[i].rav; RAaddr = tbl[i].raa;
      WAvalid = tbl[i].wav; WAaddr = tbl[i].waa;
      WBempty = tbl[i].wbe; DcmdReady = tbl[i].rdy; DwrNext = tbl[i].dwn;
      @(negedge Rclk);
      chk($sformatf("vec%0d {val,wr,addr,rare,ware,wbre,busy,unr}", i),
          64'({DcmdValid, DcmdWrite, DcmdAddr, RAre, WAre, WBre, Busy, Underrun}),
          64'({tbl[i].e_val, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_rare,
               tbl[i].e_ware, tbl[i].e_wbre, tbl[i].e_busy, tbl[i].e_unr}));
    end

    // Starvation: reads continuously valid, write eligible from the first cycle
    do_reset();
    RAvalid = 1'b1; RAaddr = 27'h55; WAvalid = 1'b1; WAaddr = 27'h200;
    WBempty = 1'b0; DcmdReady = 1'b1;
    nrd = 0; found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Rclk);
      if (RAre) nrd++;
      if (DcmdValid && DcmdWrite) begin
        found = 1'b1;
        break;
      end
      @(posedge Rclk); #1;
    end
    chk("starve write seen", 64'(found), 64'd1);
    chk("starve reads before write", 64'(nrd), 64'd32);
    chk("starve write addr", 64'(DcmdAddr), 64'h200);
    chk("starve WAre", 64'(WAre), 64'd1);
    @(posedge Rclk); #1;
    WAvalid = 1'b0; DwrNext = 1'b1;
    nwb = 0; got_rd = 1'b0; extra_wr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Rclk);
      if (WBre) nwb++;
      if (DcmdValid && DcmdWrite) extra_wr++;
      if (DcmdValid && !DcmdWrite) begin
        got_rd = 1'b1;
        break;
      end
      @(posedge Rclk); #1;
    end
    chk("starve burst WBre count", 64'(nwb), 64'd2);
    chk("starve read resumes", 64'(got_rd), 64'd1);
    chk("starve no extra write", 64'(extra_wr), 64'd0);

    // Batching: 12 writes queued, reads become valid once the first write is accepted
    do_reset();
    k = 0;
    WAvalid = 1'b1; WAaddr = 27'h300; WBempty = 1'b0;
    DcmdReady = 1'b1; DwrNext = 1'b1; RAvalid = 1'b0; RAaddr = 27'h77;
    nacc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Rclk);
      if (DcmdValid && DcmdReady && nacc < 16) begin
        acc_wr[nacc] = DcmdWrite;
        acc_addr[nacc] = DcmdAddr;
        nacc++;
      end
      pop = WAre;
      if (nacc == 9) break;
      @(posedge Rclk); #1;
      if (pop) k++;
      WAaddr = AW'(27'h300 + k);
      WAvalid = (k < 12);
      if (nacc >= 1) RAvalid = 1'b1;
    end
    chk("batch commands seen", 64'(nacc), 64'd9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("batch cmd%0d write", i), 64'(acc_wr[i]), 64'd1);
      chk($sformatf("batch cmd%0d addr", i), 64'(acc_addr[i]), 64'(27'h300 + i));
    end
    chk("batch cmd8 is read", 64'(acc_wr[8]), 64'd0);
    chk("batch cmd8 addr", 64'(acc_addr[8]), 64'h77);

    // Stall: command must hold while DcmdReady is low and WAaddr moves
    do_reset();
    RAvalid = 1'b0; RAaddr = 27'h0;
    WAvalid = 1'b1; WAaddr = 27'h400; WBempty = 1'b0; DcmdReady = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Rclk);
      if (DcmdValid) begin
        found = 1'b1;
        break;
      end
      @(posedge Rclk); #1;
    end
    chk("stall cmd appears", 64'(found), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge Rclk); #1;
      WAaddr = AW'(27'h401 + i);
      @(negedge Rclk);
      chk($sformatf("stall%0d {val,wr,addr,ware}", i),
          64'({DcmdValid, DcmdWrite, DcmdAddr, WAre}),
          64'({1'b1, 1'b1, 27'h400, 1'b0}));
    end
    @(posedge Rclk); #1;
    DcmdReady = 1'b1;
    @(negedge Rclk);
    chk("stall release WAre", 64'(WAre), 64'd1);
    chk("stall release addr", 64'(DcmdAddr), 64'h400);

    // Underrun inside the burst, then reset with one word still outstanding
    @(posedge Rclk); #1;
    WAvalid = 1'b0; WBempty = 1'b1; DwrNext = 1'b1;
    @(negedge Rclk);
    chk("underrun WBre still driven", 64'(WBre), 64'd1);
    chk("underrun not yet set", 64'(Underrun), 64'd0);
    @(posedge Rclk); #1;
    DwrNext = 1'b0;
    @(negedge Rclk);
    chk("underrun set", 64'(Underrun), 64'd1);
    chk("underrun mid-burst busy", 64'(Busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge Rclk); #1;
      @(negedge Rclk);
      chk($sformatf("underrun sticky%0d", i), 64'(Underrun), 64'd1);
    end
    @(posedge Rclk); #1;
    Reset = 1'b1; DwrNext = 1'b1;
    @(posedge Rclk); #1;
    @(negedge Rclk);
    chk_reset_vals("midburst reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
